ad9866_spi_ctrl: RTL

// - SPI configuration sequencer and arbiter for the AD9866 serial port (sclk/sdio/sdo/sen_n/rst_n).
// - After reset it pulses ad9866_rst_n, then plays a parameterised init table.
// - Afterwards it shares the SPI port between two requesters: RX gain tracking and host register writes.
// - Instantiated inside hermes_lite_core on the ad9866spiclk domain.

---
 rtl/ad9866_spi_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ad9866_spi_ctrl.sv
// AD9866 SPI sequencer: chip reset pulse, init table playback, then gain-tracking / host arbitration.
// Define AD9866_SPI_READ_EN to enable host register reads (rw=1 frames sampling ad9866_sdo).
module ad9866_spi_ctrl #(
  parameter int                     CLK_DIV    = 4,
  parameter int                     RST_CYCLES = 64,
  parameter int                     NUM_INIT   = 4,
  parameter logic [NUM_INIT*16-1:0] INIT_TABLE = {16'h0741, 16'h0621, 16'h0481, 16'h0080},
  parameter logic [5:0]             GAIN_ADDR  = 6'h09
) (
  input  logic       ad9866spiclk,
  input  logic       reset,
  input  logic [5:0] gain_in,
  input  logic       req_valid,
  input  logic       req_rw,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       init_done,
  output logic       ad9866_sclk,
  output logic       ad9866_sdio,
  input  logic       ad9866_sdo,
  output logic       ad9866_sen_n,
  output logic       ad9866_rst_n
);

  typedef enum logic [2:0] {RST_HOLD, RST_WAIT, IDLE, LOAD, SHIFT, GAP} state_e;
  typedef enum logic [1:0] {K_INIT, K_GAIN, K_HOST} kind_e;

  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [3:0]  INIT_LAST = 4'(NUM_INIT - 1);

  state_e      state_q;
  kind_e       kind_q;
  logic [15:0] cnt_q, hcnt_q, sh_q;
  logic [3:0]  bit_q, init_idx_q;
  logic [5:0]  gain_cap_q, last_gain_q;
  logic        gain_vld_q, init_done_q, busy_q, req_ready_q;
  logic        sclk_q, sdio_q, sen_n_q, rst_n_q;

  logic        host_rd, gain_pend, go, in_frame, half_end, bit_rise, frame_end;
  kind_e       sel_kind;
  logic [15:0] sel_frame, init_frame, gain_frame, host_frame;

  assign init_frame = INIT_TABLE[16*int'(init_idx_q) +: 16];
  assign gain_frame = {3'b000, GAIN_ADDR[4:0], 2'b01, gain_in};
  assign host_frame = {host_rd, 2'b00, req_addr[4:0], host_rd ? 8'h00 : req_data};
  assign gain_pend  = (gain_in != last_gain_q) || !gain_vld_q;

  assign in_frame  = (state_q == LOAD) || (state_q == SHIFT);
  assign half_end  = (hcnt_q == HALF_LAST);
  assign bit_rise  = in_frame && half_end && !sclk_q;
  assign frame_end = in_frame && half_end && sclk_q && (bit_q == 4'd0);

  // Fixed priority: init table, then gain tracking, then host (host only after init).
  always_comb begin
    go        = 1'b1;
    sel_kind  = K_INIT;
    sel_frame = init_frame;
    if (!init_done_q) begin
      sel_kind  = K_INIT;
      sel_frame = init_frame;
    end else if (gain_pend) begin
      sel_kind  = K_GAIN;
      sel_frame = gain_frame;
    end else if (req_valid) begin
      sel_kind  = K_HOST;
      sel_frame = host_frame;
    end else begin
      go = 1'b0;
    end
  end

  always_ff @(posedge ad9866spiclk) begin
    if (reset) begin
      state_q     <= RST_HOLD;
      kind_q      <= K_INIT;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      sh_q        <= '0;
      bit_q       <= '0;
      init_idx_q  <= '0;
      gain_cap_q  <= '0;
      last_gain_q <= 6'h3F;
      gain_vld_q  <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b0;
      sclk_q      <= 1'b0;
      sdio_q      <= 1'b0;
      sen_n_q     <= 1'b1;
      rst_n_q     <= 1'b0;
    end else begin
      req_ready_q <= 1'b0;
      case (state_q)
        RST_HOLD: begin
          if (cnt_q == RST_LAST) begin
            cnt_q   <= '0;
            rst_n_q <= 1'b1;
            state_q <= RST_WAIT;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RST_WAIT: begin
          if (cnt_q == RST_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        IDLE: begin
          if (go) begin
            state_q     <= LOAD;
            kind_q      <= sel_kind;
            sh_q        <= sel_frame;
            sdio_q      <= sel_frame[15];
            sen_n_q     <= 1'b0;
            sclk_q      <= 1'b0;
            busy_q      <= 1'b1;
            hcnt_q      <= '0;
            bit_q       <= 4'd15;
            gain_cap_q  <= gain_in;
            req_ready_q <= (sel_kind == K_HOST);
          end
        end
        // LOAD is the first low-half cycle of bit 15, so sen_n is low for exactly 32*CLK_DIV cycles.
        LOAD, SHIFT: begin
          if (state_q == LOAD) state_q <= SHIFT;
          if (half_end) begin
            hcnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == 4'd0) begin
                state_q <= GAP;
                sen_n_q <= 1'b1;
                sdio_q  <= 1'b0;
                cnt_q   <= '0;
              end else begin
                bit_q  <= bit_q - 4'd1;
                sh_q   <= {sh_q[14:0], 1'b0};
                sdio_q <= sh_q[14];
              end
            end
          end else begin
            hcnt_q <= hcnt_q + 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (kind_q == K_INIT) begin
              if (init_idx_q == INIT_LAST) init_done_q <= 1'b1;
              else                         init_idx_q  <= init_idx_q + 4'd1;
            end else if (kind_q == K_GAIN) begin
              last_gain_q <= gain_cap_q;
              gain_vld_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= RST_HOLD;
      endcase
    end
  end

`ifdef AD9866_SPI_READ_EN
  logic       rd_q, rd_valid_q;
  logic [7:0] rd_sh_q, rd_data_q;
  logic       unused_addr;

  assign host_rd     = req_rw;
  assign unused_addr = req_addr[5];

  // Read data bits 7..0 are sampled on the sclk rising edge; sdio is already 0 there.
  always_ff @(posedge ad9866spiclk) begin
    if (reset) begin
      rd_q       <= 1'b0;
      rd_sh_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (state_q == IDLE && go) rd_q <= (sel_kind == K_HOST) && host_rd;
      if (bit_rise && rd_q && bit_q <= 4'd7) rd_sh_q <= {rd_sh_q[6:0], ad9866_sdo};
      if (frame_end && rd_q) begin
        rd_data_q  <= rd_sh_q;
        rd_valid_q <= 1'b1;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_in;
  assign host_rd   = 1'b0;
  assign unused_in = ^{req_rw, ad9866_sdo, req_addr[5], bit_rise, frame_end};
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
`endif

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign init_done    = init_done_q;
  assign ad9866_sclk  = sclk_q;
  assign ad9866_sdio  = sdio_q;
  assign ad9866_sen_n = sen_n_q;
  assign ad9866_rst_n = rst_n_q;

endmodule
